division: RTL and testbench

- Iterative restoring divider for the MIPS core; implements DIV and DIVU as the inverse counterpart of the shift-add multiplier.
- Produces a quotient for LO and a remainder for HI, one quotient bit per cycle.
- Driven by the control FSM through a start/endSignal handshake.
- Results are consumed by the HI/LO register write path.

---
 rtl/mips_div_pkg.sv | 13 +
 rtl/div_sign_unit.sv | 14 +
 rtl/division.sv | 141 ++++++++++++++
 tb/tb_division.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS iterative divider.
package mips_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_WORK,
    DIV_FIXUP
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_unit.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module div_sign_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/division.sv
// Restoring divider (DIV/DIVU): quotient to LO, remainder to HI, one quotient bit per cycle.
// Optional DIV_EARLY_EXIT_EN: skip the iteration when |dividend| < |divisor|.
//
// state     | meaning
// DIV_IDLE  | results valid, waiting for start
// DIV_WORK  | one restoring step per edge, WIDTH steps
// DIV_FIXUP | apply quotient/remainder signs, publish results
module division
  import mips_div_pkg::*;
#(
  parameter int  WIDTH = DIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             endSignal,
  output logic             divZero,
  output logic [CNT_W-1:0] counter
);

  div_state_t       state, next_state;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] mag_n, mag_d, rem, q;
  logic [WIDTH-1:0] shared_in, shared_out, abs_d, fix_q;
  logic             shared_neg;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] trial_sub;
  logic             take;
  logic             accept, div_by_zero, early_exit;

  assign accept      = (state == DIV_IDLE) && start;
  assign div_by_zero = accept && (divisor == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = accept && !div_by_zero && (shared_out < abs_d);
`else
  assign early_exit = 1'b0;
`endif

  // The dividend negator is idle outside IDLE, so FIXUP borrows it for the remainder sign.
  assign shared_in  = (state == DIV_FIXUP) ? rem : dividend;
  assign shared_neg = (state == DIV_FIXUP) ? sign_r : (isSigned & dividend[WIDTH-1]);

  div_sign_unit #(.WIDTH(WIDTH)) u_shared_sign (
    .value (shared_in),
    .negate(shared_neg),
    .result(shared_out)
  );

  div_sign_unit #(.WIDTH(WIDTH)) u_abs_d (
    .value (divisor),
    .negate(isSigned & divisor[WIDTH-1]),
    .result(abs_d)
  );

  div_sign_unit #(.WIDTH(WIDTH)) u_fix_q (
    .value (q),
    .negate(sign_q),
    .result(fix_q)
  );

  // Trial value keeps the bit shifted out of rem so divisors above 2^(WIDTH-1) compare correctly.
  assign trial     = {rem, mag_n[WIDTH-1]};
  assign take      = trial >= {1'b0, mag_d};
  assign trial_sub = trial[WIDTH-1:0] - mag_d;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= DIV_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DIV_IDLE: begin
        if (accept && !div_by_zero) next_state = early_exit ? DIV_FIXUP : DIV_WORK;
      end
      DIV_WORK: begin
        if (counter == CNT_W'(WIDTH - 1)) next_state = DIV_FIXUP;
      end
      DIV_FIXUP: next_state = DIV_IDLE;
      default:   next_state = DIV_IDLE;
    endcase
  end

  always_comb begin
    endSignal = (state == DIV_IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      mag_n     <= '0;
      mag_d     <= '0;
      rem       <= '0;
      q         <= '0;
      counter   <= '0;
      quotient  <= '0;
      remainder <= '0;
      divZero   <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (div_by_zero) begin
            quotient  <= {WIDTH{1'b1}};
            remainder <= dividend;
            divZero   <= 1'b1;
          end else if (accept) begin
            sign_q  <= isSigned & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r  <= isSigned & dividend[WIDTH-1];
            mag_n   <= shared_out;
            mag_d   <= abs_d;
            rem     <= early_exit ? shared_out : '0;
            q       <= '0;
            counter <= '0;
            divZero <= 1'b0;
          end
        end
        DIV_WORK: begin
          mag_n   <= {mag_n[WIDTH-2:0], 1'b0};
          rem     <= take ? trial_sub : trial[WIDTH-1:0];
          q       <= {q[WIDTH-2:0], take};
          counter <= counter + CNT_W'(1);
        end
        DIV_FIXUP: begin
          quotient  <= fix_q;
          remainder <= shared_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Directed self-checking bench for the restoring divider.
module tb_division;
  import mips_div_pkg::*;

  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          isSigned = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [W-1:0]  quotient, remainder;
  logic          endSignal, divZero;
  logic [CW-1:0] counter;

  int checks = 0;
  int errors = 0;
  int lat;

`ifdef DIV_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = W + 1;
`endif

  always #5 Clk = ~Clk;

  division dut (
    .Clk      (Clk),
    .reset    (reset),
    .start    (start),
    .isSigned (isSigned),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .endSignal(endSignal),
    .divZero  (divZero),
    .counter  (counter)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d);
    @(negedge Clk);
    isSigned = sgn;
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat_out);
    lat_out = lat0;
    while (endSignal !== 1'b1 && lat_out < 200) begin
      @(posedge Clk);
      #1;
      lat_out++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] n,
                         input logic [W-1:0] d, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input int elat);
    int l;
    start_op(sgn, n, d);
    check({tag, " busy"}, endSignal, 1'b0);
    check({tag, " cnt_clr"}, counter, '0);
    wait_done(0, l);
    check({tag, " latency"}, l, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " divzero"}, divZero, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst endsignal", endSignal, 1'b1);
    check("rst quotient", quotient, '0);
    check("rst remainder", remainder, '0);
    check("rst counter", counter, '0);
    check("rst divzero", divZero, 1'b0);
    @(negedge Clk);
    reset = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, W + 1);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, W + 1);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, W + 1);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, W + 1);
    run_div("u_bigdiv", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, W + 1);

    // Divide by zero resolves on the start edge
    start_op(1'b0, 32'd5, 32'd0);
    check("dz divzero", divZero, 1'b1);
    check("dz quotient", quotient, DIV_ZERO_QUOTIENT);
    check("dz remainder", remainder, 32'd5);
    check("dz endsignal", endSignal, 1'b1);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, W + 1);

    // Start pulse while busy must be ignored
    start_op(1'b0, 32'd100, 32'd7);
    lat = 0;
    repeat (4) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    isSigned = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge Clk);
    #1;
    lat++;
    start = 1'b0;
    check("busy endsignal", endSignal, 1'b0);
    check("busy divzero", divZero, 1'b0);
    wait_done(lat, lat);
    check("busy latency", lat, W + 1);
    check("busy quotient", quotient, 32'd14);
    check("busy remainder", remainder, 32'd2);

    // Reset mid-operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    #1;
    check("mid_rst endsignal", endSignal, 1'b1);
    check("mid_rst quotient", quotient, '0);
    check("mid_rst remainder", remainder, '0);
    check("mid_rst counter", counter, '0);
    @(negedge Clk);
    reset = 1'b1;
    run_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, W + 1);

    run_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, SMALL_LAT);
    run_div("s-3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, SMALL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
